sincos_cordic: RTL

SINCOS_CORDIC -- requirements
Module: sincos_cordic

---
 rtl/sincos_cordic.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sincos_cordic.sv
// Sequential CORDIC sine/cosine generator.
// One micro-rotation per clock on guard-extended x/y/z registers, then a
// single finishing cycle that folds the quadrant back in and clamps each
// result symmetrically to the signed output range.
module sincos_cordic #(
  parameter int WIDTH = 16,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] angle,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sin_result,
  output logic [WIDTH-1:0] cos_result
);

  localparam int XW = WIDTH + 2;
  localparam int CW = $clog2(ITER + 1);

  // CORDIC gain compensation 0.6072529 in Q0.32, pre-scaled to 2^(WIDTH-1).
  localparam logic [31:0]          K_Q32     = 32'h9B74EDA8;
  localparam logic signed [XW-1:0] X_INIT    = XW'(K_Q32 >> (33 - WIDTH));
  localparam logic signed [XW-1:0] MAX_MAG   = XW'((2 ** (WIDTH - 1)) - 1);
  localparam logic [CW-1:0]        LAST_ITER = CW'(ITER - 1);

  // atan(2^-i) / (2*pi) * 2^32, one full turn = 2^32.
  localparam logic [31:0] ATAN_TABLE [0:31] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
  };

  typedef enum logic [1:0] {IDLE, ROTATE, FINISH} stateT;

  stateT                 r_state;
  stateT                 w_nextState;
  logic [CW-1:0]         r_iter;
  logic signed [XW-1:0]  r_x;
  logic signed [XW-1:0]  r_y;
  logic signed [XW-1:0]  r_z;
  logic [1:0]            r_quad;
  logic [1:0]            r_mode;
  logic                  r_done;
  logic [WIDTH-1:0]      r_sin;
  logic [WIDTH-1:0]      r_cos;

  logic [4:0]            w_tabIdx;
  logic signed [XW-1:0]  w_atan;
  logic signed [XW-1:0]  w_xShift;
  logic signed [XW-1:0]  w_yShift;
  logic                  w_zNeg;
  logic signed [XW-1:0]  w_sinPre;
  logic signed [XW-1:0]  w_cosPre;

  assign w_tabIdx = 5'(r_iter);
  assign w_atan   = XW'(ATAN_TABLE[w_tabIdx] >> (32 - WIDTH));
  assign w_xShift = r_x >>> r_iter;
  assign w_yShift = r_y >>> r_iter;
  assign w_zNeg   = r_z[XW-1];

  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign sin_result = r_sin;
  assign cos_result = r_cos;

  // x and y already sit at output scale; the two guard bits are integer
  // headroom, so narrowing is exact and only needs the symmetric clamp
  // that keeps -2^(WIDTH-1) out of the result.
  function automatic logic [WIDTH-1:0] clampToOutput(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] lim;
    if (v > MAX_MAG)       lim = MAX_MAG;
    else if (v < -MAX_MAG) lim = -MAX_MAG;
    else                   lim = v;
    return lim[WIDTH-1:0];
  endfunction

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic: start is only looked at while idle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = ROTATE;
      ROTATE:  if (r_iter == LAST_ITER) w_nextState = FINISH;
      FINISH:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Quadrant fold-back: the rotation only covers the first quarter turn.
  always_comb begin
    w_sinPre = r_y;
    w_cosPre = r_x;
    case (r_quad)
      2'd0: begin w_sinPre = r_y;  w_cosPre = r_x;  end
      2'd1: begin w_sinPre = r_x;  w_cosPre = -r_y; end
      2'd2: begin w_sinPre = -r_y; w_cosPre = -r_x; end
      default: begin w_sinPre = -r_x; w_cosPre = r_y; end
    endcase
  end

  // Datapath: load on accept, rotate once per cycle, publish on finish.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_iter <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_quad <= '0;
      r_mode <= '0;
      r_done <= 1'b0;
      r_sin  <= '0;
      r_cos  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_quad <= angle[WIDTH-1:WIDTH-2];
            r_mode <= mode;
            r_x    <= X_INIT;
            r_y    <= '0;
            r_z    <= {4'b0000, angle[WIDTH-3:0]};
            r_iter <= '0;
          end
        end
        ROTATE: begin
          if (!w_zNeg) begin
            r_x <= r_x - w_yShift;
            r_y <= r_y + w_xShift;
            r_z <= r_z - w_atan;
          end else begin
            r_x <= r_x + w_yShift;
            r_y <= r_y - w_xShift;
            r_z <= r_z + w_atan;
          end
          r_iter <= r_iter + CW'(1);
        end
        FINISH: begin
          r_done <= 1'b1;
          if (r_mode != 2'b01) r_sin <= clampToOutput(w_sinPre);
          if (r_mode != 2'b00) r_cos <= clampToOutput(w_cosPre);
        end
        default: ;
      endcase
    end
  end

endmodule
